// File: rtl/ip_rx_demux_pkg.sv
// ip_rx_demux_pkg
// Shared IPv4 constants, the receive FSM state type and the ones'-complement
// byte accumulate helper used by the header checksum logic.
package ip_rx_demux_pkg;

    localparam logic [3:0]  IP_VERSION_4 = 4'd4;
    localparam logic [3:0]  IHL_MIN      = 4'd5;
    localparam logic [7:0]  PROTO_ICMP   = 8'd1;
    localparam logic [7:0]  PROTO_UDP    = 8'd17;
    localparam logic [31:0] IP_BROADCAST = 32'hFFFF_FFFF;
    localparam logic [15:0] CSUM_GOOD    = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        OPT     = 3'd2,
        PAYLOAD = 3'd3,
        DISCARD = 3'd4
    } rx_state_e;

    // Adds one header byte to a running 16-bit ones'-complement sum. Even
    // offsets are the high byte of a word and odd offsets the low byte, so
    // adding byte by byte gives the same result as adding whole words.
    function automatic logic [15:0] csum_add_byte(input logic [15:0] sum,
                                                  input logic [7:0]  b,
                                                  input logic        odd);
        logic [15:0] w;
        logic [16:0] s;
        w = odd ? {8'h00, b} : {b, 8'h00};
        s = {1'b0, sum} + {1'b0, w};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/ip_hdr_checksum.sv
// ip_hdr_checksum
// Running ones'-complement sum of an IPv4 header presented one byte at a time.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-low reset
//   i_data        header byte
//   i_valid       i_data is a header byte to be added this cycle
//   i_clear       restart the sum; a byte valid in the same cycle becomes
//                 byte 0 (high half) of the new sum
//   o_sum         registered sum of all bytes accepted so far
module ip_hdr_checksum
    import ip_rx_demux_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    input  logic        i_clear,
    output logic [15:0] o_sum
);

    logic [15:0] sum_q, sum_d;
    logic        odd_q, odd_d;

    always_comb begin
        sum_d = sum_q;
        odd_d = odd_q;
        if (i_clear) begin
            sum_d = 16'h0000;
            odd_d = 1'b0;
            if (i_valid) begin
                sum_d = csum_add_byte(16'h0000, i_data, 1'b0);
                odd_d = 1'b1;
            end
        end else if (i_valid) begin
            sum_d = csum_add_byte(sum_q, i_data, odd_q);
            odd_d = ~odd_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sum_q <= 16'h0000;
            odd_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            odd_q <= odd_d;
        end
    end

    assign o_sum = sum_q;

endmodule

// File: rtl/ip_rx_demux.sv
// ip_rx_demux
// Parses IPv4 datagrams from the MAC RX byte stream, validates the header and
// forwards the payload to the ICMP or UDP channel with one cycle of latency.
// Handshake: all streams are valid-only with no backpressure; a byte (and its
// last flag) transfers in every cycle its valid is high, and cycles with valid
// low carry nothing and change nothing.
// Ports:
//   i_clk, i_rst                        clock, asynchronous active-low reset
//   i_mac_data/valid/last               IPv4 datagram bytes from the MAC
//   o_icmp_len/data/last/valid          ICMP payload stream and payload length
//   o_udp_len/data/last/valid           UDP payload stream and payload length
//   o_src_ip                            source address of the forwarded datagram
//   o_drop                              one-cycle pulse per rejected/truncated datagram
//   o_dbg_state                         current FSM state (rx_state_e encoding)
module ip_rx_demux
    import ip_rx_demux_pkg::*;
#(
    parameter logic [31:0] P_LOCAL_IP = 32'hC0A8_0164
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_mac_data,
    input  logic        i_mac_valid,
    input  logic        i_mac_last,
    output logic [15:0] o_icmp_len,
    output logic [7:0]  o_icmp_data,
    output logic        o_icmp_last,
    output logic        o_icmp_valid,
    output logic [15:0] o_udp_len,
    output logic [7:0]  o_udp_data,
    output logic        o_udp_last,
    output logic        o_udp_valid,
    output logic [31:0] o_src_ip,
    output logic        o_drop,
    output logic [2:0]  o_dbg_state
);

    rx_state_e   state_q, state_d;
    // Set by reset: a reset may land mid-datagram, so everything up to the
    // next i_mac_last is ignored before parsing starts again.
    logic        wait_eof_q, wait_eof_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  ver_q, ver_d;
    logic [3:0]  ihl_q, ihl_d;
    logic [15:0] tl_q, tl_d;
    logic [13:0] frag_q, frag_d;   // MF flag and 13-bit fragment offset
    logic [7:0]  proto_q, proto_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] pay_len_q, pay_len_d;
    logic        is_udp_q, is_udp_d;

    logic [15:0] icmp_len_q, icmp_len_d;
    logic [7:0]  icmp_data_q, icmp_data_d;
    logic        icmp_last_q, icmp_last_d;
    logic        icmp_valid_q, icmp_valid_d;
    logic [15:0] udp_len_q, udp_len_d;
    logic [7:0]  udp_data_q, udp_data_d;
    logic        udp_last_q, udp_last_d;
    logic        udp_valid_q, udp_valid_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic        drop_q, drop_d;

    logic [15:0] csum_sum;
    logic [15:0] csum_now;
    logic        csum_clear;
    logic        csum_valid;
    logic [15:0] hdr_len;
    logic [31:0] dst_now;
    logic        hdr_done;
    logic        accept;
    logic        pay_last;

    ip_hdr_checksum u_csum (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_data  (i_mac_data),
        .i_valid (csum_valid),
        .i_clear (csum_clear),
        .o_sum   (csum_sum)
    );

    assign csum_clear = (state_q == IDLE);
    assign csum_valid = i_mac_valid &&
                        (((state_q == IDLE) && !wait_eof_q) ||
                         (state_q == HDR) || (state_q == OPT));

    assign hdr_len = {10'd0, ihl_q, 2'b00};

    // The decision is taken while the last header byte is on the bus, so the
    // checksum and destination are completed combinationally with that byte.
    // The last header byte is always at an odd offset (low half of a word).
    assign csum_now = csum_add_byte(csum_sum, i_mac_data, 1'b1);
    assign dst_now  = (state_q == HDR) ? {dst_q[23:0], i_mac_data} : dst_q;

    assign hdr_done = i_mac_valid && !i_mac_last &&
                      (((state_q == HDR) && (cnt_q == 16'd19) && (ihl_q <= IHL_MIN)) ||
                       ((state_q == OPT) && (cnt_q == hdr_len - 16'd1)));

    assign accept = (ver_q == IP_VERSION_4) &&
                    (ihl_q >= IHL_MIN) &&
                    ((dst_now == P_LOCAL_IP) || (dst_now == IP_BROADCAST)) &&
                    (frag_q == 14'd0) &&
                    (csum_now == CSUM_GOOD) &&
                    ((proto_q == PROTO_ICMP) || (proto_q == PROTO_UDP)) &&
                    (tl_q > hdr_len);

    assign pay_last = (cnt_q == pay_len_q - 16'd1);

    always_comb begin
        state_d      = state_q;
        wait_eof_d   = wait_eof_q;
        cnt_d        = cnt_q;
        ver_d        = ver_q;
        ihl_d        = ihl_q;
        tl_d         = tl_q;
        frag_d       = frag_q;
        proto_d      = proto_q;
        src_d        = src_q;
        dst_d        = dst_q;
        pay_len_d    = pay_len_q;
        is_udp_d     = is_udp_q;
        icmp_len_d   = icmp_len_q;
        icmp_data_d  = icmp_data_q;
        icmp_last_d  = 1'b0;
        icmp_valid_d = 1'b0;
        udp_len_d    = udp_len_q;
        udp_data_d   = udp_data_q;
        udp_last_d   = 1'b0;
        udp_valid_d  = 1'b0;
        src_ip_d     = src_ip_q;
        drop_d       = 1'b0;

        if (i_mac_valid) begin
            case (state_q)
                IDLE: begin
                    if (wait_eof_q) begin
                        if (i_mac_last) wait_eof_d = 1'b0;
                    end else begin
                        ver_d = i_mac_data[7:4];
                        ihl_d = i_mac_data[3:0];
                        cnt_d = 16'd1;
                        if (i_mac_last) drop_d  = 1'b1;
                        else            state_d = HDR;
                    end
                end
                HDR: begin
                    cnt_d = cnt_q + 16'd1;
                    case (cnt_q)
                        16'd2:  tl_d[15:8]  = i_mac_data;
                        16'd3:  tl_d[7:0]   = i_mac_data;
                        16'd6:  frag_d[13:8] = i_mac_data[5:0];
                        16'd7:  frag_d[7:0]  = i_mac_data;
                        16'd9:  proto_d     = i_mac_data;
                        16'd12, 16'd13, 16'd14, 16'd15:
                                src_d = {src_q[23:0], i_mac_data};
                        16'd16, 16'd17, 16'd18, 16'd19:
                                dst_d = {dst_q[23:0], i_mac_data};
                        default: ;
                    endcase
                    if (i_mac_last) begin
                        drop_d  = 1'b1;
                        state_d = IDLE;
                    end else if ((cnt_q == 16'd19) && (ihl_q > IHL_MIN)) begin
                        state_d = OPT;
                    end
                end
                OPT: begin
                    cnt_d = cnt_q + 16'd1;
                    if (i_mac_last) begin
                        drop_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                PAYLOAD: begin
                    if (is_udp_q) begin
                        udp_valid_d = 1'b1;
                        udp_data_d  = i_mac_data;
                        udp_last_d  = pay_last || i_mac_last;
                    end else begin
                        icmp_valid_d = 1'b1;
                        icmp_data_d  = i_mac_data;
                        icmp_last_d  = pay_last || i_mac_last;
                    end
                    cnt_d = cnt_q + 16'd1;
                    if (pay_last) begin
                        // Anything after the final payload byte is padding.
                        state_d = i_mac_last ? IDLE : DISCARD;
                    end else if (i_mac_last) begin
                        drop_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                DISCARD: begin
                    if (i_mac_last) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (hdr_done) begin
            cnt_d = 16'd0;
            if (accept) begin
                state_d   = PAYLOAD;
                pay_len_d = tl_q - hdr_len;
                src_ip_d  = src_q;
                if (proto_q == PROTO_UDP) begin
                    is_udp_d  = 1'b1;
                    udp_len_d = tl_q - hdr_len;
                end else begin
                    is_udp_d   = 1'b0;
                    icmp_len_d = tl_q - hdr_len;
                end
            end else begin
                state_d = DISCARD;
                drop_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= IDLE;
            wait_eof_q   <= 1'b1;
            cnt_q        <= 16'd0;
            ver_q        <= 4'd0;
            ihl_q        <= 4'd0;
            tl_q         <= 16'd0;
            frag_q       <= 14'd0;
            proto_q      <= 8'd0;
            src_q        <= 32'd0;
            dst_q        <= 32'd0;
            pay_len_q    <= 16'd0;
            is_udp_q     <= 1'b0;
            icmp_len_q   <= 16'd0;
            icmp_data_q  <= 8'd0;
            icmp_last_q  <= 1'b0;
            icmp_valid_q <= 1'b0;
            udp_len_q    <= 16'd0;
            udp_data_q   <= 8'd0;
            udp_last_q   <= 1'b0;
            udp_valid_q  <= 1'b0;
            src_ip_q     <= 32'd0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_eof_q   <= wait_eof_d;
            cnt_q        <= cnt_d;
            ver_q        <= ver_d;
            ihl_q        <= ihl_d;
            tl_q         <= tl_d;
            frag_q       <= frag_d;
            proto_q      <= proto_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            pay_len_q    <= pay_len_d;
            is_udp_q     <= is_udp_d;
            icmp_len_q   <= icmp_len_d;
            icmp_data_q  <= icmp_data_d;
            icmp_last_q  <= icmp_last_d;
            icmp_valid_q <= icmp_valid_d;
            udp_len_q    <= udp_len_d;
            udp_data_q   <= udp_data_d;
            udp_last_q   <= udp_last_d;
            udp_valid_q  <= udp_valid_d;
            src_ip_q     <= src_ip_d;
            drop_q       <= drop_d;
        end
    end

    assign o_icmp_len   = icmp_len_q;
    assign o_icmp_data  = icmp_data_q;
    assign o_icmp_last  = icmp_last_q;
    assign o_icmp_valid = icmp_valid_q;
    assign o_udp_len    = udp_len_q;
    assign o_udp_data   = udp_data_q;
    assign o_udp_last   = udp_last_q;
    assign o_udp_valid  = udp_valid_q;
    assign o_src_ip     = src_ip_q;
    assign o_drop       = drop_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_ip_rx_demux.sv
// tb_ip_rx_demux
// Directed and randomised datagrams for ip_rx_demux. Each output byte is
// recorded as {channel, src_ip, len, last, data} and checked against the
// entries the frame builder queued when the frame was generated.
module tb_ip_rx_demux;

    localparam logic [31:0] LOCAL_IP = 32'hC0A8_0164;
    localparam int W = 58;

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_mac_data;
    logic        i_mac_valid;
    logic        i_mac_last;
    logic [15:0] o_icmp_len;
    logic [7:0]  o_icmp_data;
    logic        o_icmp_last;
    logic        o_icmp_valid;
    logic [15:0] o_udp_len;
    logic [7:0]  o_udp_data;
    logic        o_udp_last;
    logic        o_udp_valid;
    logic [31:0] o_src_ip;
    logic        o_drop;
    logic [2:0]  o_dbg_state;

    ip_rx_demux #(.P_LOCAL_IP(LOCAL_IP)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_mac_data   (i_mac_data),
        .i_mac_valid  (i_mac_valid),
        .i_mac_last   (i_mac_last),
        .o_icmp_len   (o_icmp_len),
        .o_icmp_data  (o_icmp_data),
        .o_icmp_last  (o_icmp_last),
        .o_icmp_valid (o_icmp_valid),
        .o_udp_len    (o_udp_len),
        .o_udp_data   (o_udp_data),
        .o_udp_last   (o_udp_last),
        .o_udp_valid  (o_udp_valid),
        .o_src_ip     (o_src_ip),
        .o_drop       (o_drop),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, bench did not finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    int drop_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    logic [7:0]   frm_q[$];
    logic         lst_q[$];

    always @(negedge i_clk) begin
        if (o_icmp_valid) obs_q.push_back({1'b0, o_src_ip, o_icmp_len, o_icmp_last, o_icmp_data});
        if (o_udp_valid)  obs_q.push_back({1'b1, o_src_ip, o_udp_len, o_udp_last, o_udp_data});
        if (o_drop)       drop_cnt++;
    end

    // ---------------- driver tasks ----------------
    // Builds one datagram into frm_q/lst_q. exp_ch: 0 = must be rejected,
    // 1 = ICMP, 2 = UDP. frame_len below tl truncates, above tl pads.
    task automatic make_frame(input logic [15:0] tl, input logic [3:0] ihl,
                              input logic [15:0] ff, input logic [7:0] proto,
                              input logic [31:0] dst, input logic [15:0] csum_adj,
                              input int frame_len, input int exp_ch);
        logic [7:0]  b[$];
        logic [31:0] src;
        logic [31:0] acc;
        logic [15:0] csum;
        logic [15:0] plen;
        int hl;
        int n;
        hl  = int'(ihl) * 4;
        src = $urandom;
        b.push_back({4'h4, ihl});
        b.push_back(8'h00);
        b.push_back(tl[15:8]);
        b.push_back(tl[7:0]);
        b.push_back(8'($urandom_range(0, 255)));
        b.push_back(8'($urandom_range(0, 255)));
        b.push_back(ff[15:8]);
        b.push_back(ff[7:0]);
        b.push_back(8'h40);
        b.push_back(proto);
        b.push_back(8'h00);
        b.push_back(8'h00);
        for (int k = 3; k >= 0; k--) b.push_back(src[8*k +: 8]);
        for (int k = 3; k >= 0; k--) b.push_back(dst[8*k +: 8]);
        for (int k = 20; k < hl; k++) b.push_back(8'($urandom_range(0, 255)));
        acc = 32'd0;
        for (int k = 0; k < hl; k += 2) acc = acc + {16'd0, b[k], b[k+1]};
        while (acc[31:16] != 16'd0) acc = {16'd0, acc[15:0]} + {16'd0, acc[31:16]};
        csum  = ~acc[15:0] + csum_adj;
        b[10] = csum[15:8];
        b[11] = csum[7:0];
        for (int k = hl; k < frame_len; k++) b.push_back(8'($urandom_range(0, 255)));
        for (int k = 0; k < b.size(); k++) begin
            frm_q.push_back(b[k]);
            lst_q.push_back(k == b.size() - 1);
        end
        if (exp_ch != 0) begin
            plen = tl - 16'(hl);
            n = ((frame_len < int'(tl)) ? frame_len : int'(tl)) - hl;
            for (int i = 0; i < n; i++)
                exp_q.push_back({(exp_ch == 2), src, plen, (i == n - 1), b[hl + i]});
        end
    endtask

    task automatic drive_bytes(input int from, input int to, input int gap_max);
        for (int i = from; i < to; i++) begin
            int g;
            g = int'($urandom_range(0, gap_max));
            repeat (g) begin
                i_mac_valid = 1'b0;
                i_mac_data  = 8'($urandom_range(0, 255));
                i_mac_last  = 1'b0;
                @(posedge i_clk); #1;
            end
            i_mac_valid = 1'b1;
            i_mac_data  = frm_q[i];
            i_mac_last  = lst_q[i];
            @(posedge i_clk); #1;
        end
        i_mac_valid = 1'b0;
        i_mac_last  = 1'b0;
    endtask

    task automatic finish_frames();
        repeat (4) @(posedge i_clk);
        #1;
        frm_q.delete();
        lst_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        total++;
        if ({o_icmp_len, o_icmp_data, o_icmp_last, o_icmp_valid, o_udp_len, o_udp_data,
             o_udp_last, o_udp_valid, o_src_ip, o_drop} !== 85'd0) begin
            bad++;
            $display("FAIL reset_outputs got icmp_len=%h udp_len=%h src=%h drop=%b required all zero",
                     o_icmp_len, o_udp_len, o_src_ip, o_drop);
        end
        total++;
        if (o_dbg_state !== 3'd0) begin
            bad++;
            $display("FAIL reset_state got=%0d required=0", o_dbg_state);
        end
        #4 i_rst = 1'b1;
        @(posedge i_clk); #1;
        // Bytes after reset are ignored up to the first last byte.
        drop_cnt = 0;
        make_frame(16'd30, 4'd5, 16'h0000, 8'd1, LOCAL_IP, 16'd0, 30, 0);
        drive_bytes(0, frm_q.size(), 0);
        finish_frames();
        total++;
        if (obs_q.size() != 0 || drop_cnt != 0) begin
            bad++;
            $display("FAIL reset_resync got bytes=%0d drops=%0d required bytes=0 drops=0",
                     obs_q.size(), drop_cnt);
            obs_q.delete();
        end
    endtask

    task automatic test_icmp_echo();
        logic [W-1:0] e, o;
        drop_cnt = 0;
        make_frame(16'd60, 4'd5, 16'h0000, 8'd1, LOCAL_IP, 16'd0, 60, 1);
        drive_bytes(0, frm_q.size(), 0);
        finish_frames();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL echo_byte got=%h required=%h", o, e); end
        end
        total++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL echo_count left exp=%0d obs=%0d required 0/0", exp_q.size(), obs_q.size());
            exp_q.delete(); obs_q.delete();
        end
        total++;
        if (drop_cnt != 0) begin bad++; $display("FAIL echo_drop got=%0d required=0", drop_cnt); end
    endtask

    task automatic test_udp_padded();
        logic [W-1:0] e, o;
        drop_cnt = 0;
        make_frame(16'd46, 4'd5, 16'h4000, 8'd17, LOCAL_IP, 16'd0, 60, 2);
        drive_bytes(0, frm_q.size(), 2);
        finish_frames();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL udp_byte got=%h required=%h", o, e); end
        end
        total++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL udp_count left exp=%0d obs=%0d required 0/0", exp_q.size(), obs_q.size());
            exp_q.delete(); obs_q.delete();
        end
        total++;
        if (drop_cnt != 0) begin bad++; $display("FAIL udp_drop got=%0d required=0", drop_cnt); end
    endtask

    task automatic test_bad_checksum();
        logic [W-1:0] e, o;
        drop_cnt = 0;
        make_frame(16'd40, 4'd5, 16'h0000, 8'd1, LOCAL_IP, 16'd1, 40, 0);
        make_frame(16'd50, 4'd5, 16'h0000, 8'd1, LOCAL_IP, 16'd0, 60, 1);
        drive_bytes(0, frm_q.size(), 0);
        finish_frames();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL csum_byte got=%h required=%h", o, e); end
        end
        total++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL csum_count left exp=%0d obs=%0d required 0/0", exp_q.size(), obs_q.size());
            exp_q.delete(); obs_q.delete();
        end
        total++;
        if (drop_cnt != 1) begin bad++; $display("FAIL csum_drop got=%0d required=1", drop_cnt); end
    endtask

    task automatic test_options();
        logic [W-1:0] e, o;
        drop_cnt = 0;
        make_frame(16'd32, 4'd6, 16'h0000, 8'd1, LOCAL_IP, 16'd0, 60, 1);
        drive_bytes(0, frm_q.size(), 1);
        finish_frames();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL opt_byte got=%h required=%h", o, e); end
        end
        total++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL opt_count left exp=%0d obs=%0d required 0/0", exp_q.size(), obs_q.size());
            exp_q.delete(); obs_q.delete();
        end
        total++;
        if (drop_cnt != 0) begin bad++; $display("FAIL opt_drop got=%0d required=0", drop_cnt); end
    endtask

    task automatic test_rejects();
        logic [W-1:0] e, o;
        drop_cnt = 0;
        make_frame(16'd40, 4'd5, 16'h0000, 8'd17, 32'hC0A8_01C8, 16'd0, 40, 0);
        make_frame(16'd40, 4'd5, 16'h0000, 8'd6,  LOCAL_IP,      16'd0, 40, 0);
        make_frame(16'd40, 4'd5, 16'h2000, 8'd1,  LOCAL_IP,      16'd0, 40, 0);
        make_frame(16'd40, 4'd5, 16'h0005, 8'd17, LOCAL_IP,      16'd0, 40, 0);
        make_frame(16'd20, 4'd5, 16'h0000, 8'd1,  LOCAL_IP,      16'd0, 46, 0);
        make_frame(16'd33, 4'd5, 16'h0000, 8'd17, 32'hFFFF_FFFF, 16'd0, 60, 2);
        drive_bytes(0, frm_q.size(), 1);
        finish_frames();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL reject_byte got=%h required=%h", o, e); end
        end
        total++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL reject_count left exp=%0d obs=%0d required 0/0", exp_q.size(), obs_q.size());
            exp_q.delete(); obs_q.delete();
        end
        total++;
        if (drop_cnt != 5) begin bad++; $display("FAIL reject_drop got=%0d required=5", drop_cnt); end
    endtask

    task automatic test_truncate_reset();
        logic [W-1:0] e, o;
        drop_cnt = 0;
        // Frame cut after payload byte 10 of 40.
        make_frame(16'd60, 4'd5, 16'h0000, 8'd1, LOCAL_IP, 16'd0, 30, 1);
        drive_bytes(0, frm_q.size(), 0);
        finish_frames();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL trunc_byte got=%h required=%h", o, e); end
        end
        total++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL trunc_count left exp=%0d obs=%0d required 0/0", exp_q.size(), obs_q.size());
            exp_q.delete(); obs_q.delete();
        end
        total++;
        if (drop_cnt != 1) begin bad++; $display("FAIL trunc_drop got=%0d required=1", drop_cnt); end

        // Reset lands in the middle of the next header.
        drop_cnt = 0;
        make_frame(16'd60, 4'd5, 16'h0000, 8'd17, LOCAL_IP, 16'd0, 60, 0);
        drive_bytes(0, 8, 0);
        i_mac_valid = 1'b1;
        i_mac_data  = frm_q[8];
        #3 i_rst = 1'b0;
        #1;
        total++;
        if ({o_icmp_len, o_icmp_data, o_icmp_last, o_icmp_valid, o_udp_len, o_udp_data,
             o_udp_last, o_udp_valid, o_src_ip, o_drop, o_dbg_state} !== 88'd0) begin
            bad++;
            $display("FAIL midreset_outputs got icmp_len=%h src=%h state=%0d required all zero",
                     o_icmp_len, o_src_ip, o_dbg_state);
        end
        i_mac_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #3 i_rst = 1'b1;
        @(posedge i_clk); #1;
        drive_bytes(8, frm_q.size(), 0);
        finish_frames();
        make_frame(16'd46, 4'd5, 16'h0000, 8'd17, LOCAL_IP, 16'd0, 60, 2);
        drive_bytes(0, frm_q.size(), 0);
        finish_frames();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL after_reset_byte got=%h required=%h", o, e); end
        end
        total++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL after_reset_count left exp=%0d obs=%0d required 0/0", exp_q.size(), obs_q.size());
            exp_q.delete(); obs_q.delete();
        end
        total++;
        if (drop_cnt != 0) begin bad++; $display("FAIL after_reset_drop got=%0d required=0", drop_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e, o;
        drop_cnt = 0;
        for (int f = 0; f < 6; f++) begin
            logic [3:0] ihl;
            int pay;
            int tl;
            logic is_udp;
            ihl    = ($urandom_range(0, 1) == 1) ? 4'd6 : 4'd5;
            pay    = (f == 0) ? 1 : int'($urandom_range(1, 30));
            tl     = int'(ihl) * 4 + pay;
            is_udp = ($urandom_range(0, 1) == 1);
            make_frame(16'(tl), ihl, 16'h0000, is_udp ? 8'd17 : 8'd1, LOCAL_IP, 16'd0,
                       (tl < 60) ? 60 : tl, is_udp ? 2 : 1);
        end
        drive_bytes(0, frm_q.size(), 0);
        finish_frames();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL b2b_byte got=%h required=%h", o, e); end
        end
        total++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count left exp=%0d obs=%0d required 0/0", exp_q.size(), obs_q.size());
            exp_q.delete(); obs_q.delete();
        end
        total++;
        if (drop_cnt != 0) begin bad++; $display("FAIL b2b_drop got=%0d required=0", drop_cnt); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        i_rst       = 1'b0;
        i_mac_data  = 8'h00;
        i_mac_valid = 1'b0;
        i_mac_last  = 1'b0;
        test_reset();
        test_icmp_echo();
        test_udp_padded();
        test_bad_checksum();
        test_options();
        test_rejects();
        test_truncate_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ip_rx_demux.md
IP_RX_DEMUX -- requirements
Module: ip_rx_demux

Interface
REQ-001 SHALL have parameter P_LOCAL_IP, default 32'hC0A8_0164, the local IPv4 address that datagrams must be addressed to.
REQ-002 SHALL have port i_clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port i_rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports i_mac_data, i_mac_valid and i_mac_last, input, widths 8/1/1: the IPv4 datagram byte stream from the MAC RX stage, with last qualified by valid.
REQ-005 SHALL have ports o_icmp_len, o_icmp_data, o_icmp_last and o_icmp_valid, output, widths 16/8/1/1: the ICMP payload stream feeding the ICMP engine.
REQ-006 SHALL have ports o_udp_len, o_udp_data, o_udp_last and o_udp_valid, output, widths 16/8/1/1: the UDP payload stream.
REQ-007 SHALL have port o_src_ip, output, 32: the source address of the datagram currently being forwarded.
REQ-008 SHALL have port o_drop, output, 1: a one-cycle pulse for each datagram that is rejected or truncated.

Function
REQ-009 SHALL use the FSM states IDLE, HDR, OPT, PAYLOAD and DISCARD.
REQ-010 SHALL leave IDLE for HDR on the first i_mac_valid byte; that byte is header byte 0.
REQ-011 SHALL treat cycles with i_mac_valid low as stalls: state and counters hold and no output is valid.
REQ-012 SHALL capture the following header fields at byte offsets within the first 20 bytes:
- version/IHL at byte 0
- total length at bytes 2-3
- flags/fragment offset at bytes 6-7
- protocol at byte 9
- source IP at bytes 12-15
- destination IP at bytes 16-19
REQ-013 SHALL accumulate a 16-bit ones'-complement sum of all header words, including options and the checksum field, with end-around carry; the header is valid only when the final sum equals 16'hFFFF.
REQ-014 SHALL, after byte 19, go to OPT when IHL>5 and skip (IHL-5)*4 option bytes, otherwise evaluate acceptance directly.
REQ-015 SHALL accept a datagram only when all of the following hold:
- version=4
- IHL>=5
- destination equals P_LOCAL_IP or 32'hFFFF_FFFF
- MF=0 and fragment offset=0
- checksum valid
- protocol is 1 or 17
- total length > IHL*4
REQ-016 SHALL, on accept, enter PAYLOAD and set the selected channel's length output and o_src_ip to payload length = total length - IHL*4; these values are stable from before the first payload byte until the cycle after that channel's last.
REQ-017 SHALL, on reject, enter DISCARD and pulse o_drop.
REQ-018 SHALL forward payload bytes to the channel chosen by protocol (1 to ICMP, 17 to UDP) with exactly one cycle of registered latency; the other channel stays idle.
REQ-019 SHALL assert o_*_last with the byte at which the payload count reaches the payload length, then enter DISCARD to drop Ethernet padding.
REQ-020 SHALL return from DISCARD to IDLE on i_mac_last.
REQ-021 SHALL, if i_mac_last arrives in PAYLOAD before the payload length is reached, assert o_*_last with that byte, pulse o_drop, and go to IDLE.
REQ-022 SHALL, if i_mac_last arrives in HDR or OPT, pulse o_drop, go to IDLE, and emit no output.
REQ-023 SHALL, when i_mac_last coincides with the final payload byte, assert o_*_last once, not pulse o_drop, and go directly to IDLE.
REQ-024 SHALL use a 16-bit payload byte counter that never wraps, since the 16-bit total length bounds it.
REQ-025 SHALL start a new datagram from IDLE in the cycle immediately after a last byte, with no idle gap required.

Reset
REQ-026 SHALL, while i_rst is low, force the state to IDLE, all counters and the checksum accumulator to 0, all valid/last/o_drop outputs to 0, and all data, length and address outputs to 0.
REQ-027 SHALL, on reset assertion mid-datagram, take effect immediately with no partial last emitted; after release, bytes are ignored until the next i_mac_last and parsing resumes on the following datagram.

Structure
REQ-028 SHALL take the shared package constants from the IP package: IPv4 version 4, protocol codes ICMP=8'd1 and UDP=8'd17, minimum IHL 5, and the broadcast address.
REQ-029 SHALL implement the checksum accumulator as the sub-module ip_hdr_checksum (byte in, valid, clear, 16-bit sum out), which the IP TX stage reuses.

Verification
REQ-030 SHALL cover these directed scenarios:
- Echo request, 20-byte header, total length 60, proto 1, dest P_LOCAL_IP: o_icmp_len=40, 40 bytes out, last on byte 40, o_udp_valid never 1, o_drop=0.
- UDP datagram, total length 46, proto 17, frame padded to 60 bytes with i_mac_valid gaps: o_udp_len=26, 26 bytes, padding discarded, no drop.
- Header with checksum field corrupted by +1: no output, o_drop one pulse, next good datagram forwarded correctly.
- IHL=6 with 4 option bytes, total length 32: o_icmp_len=8, options not forwarded.
- Dest 192.168.1.200 or proto 6 or MF=1: rejected, o_drop pulse; dest 255.255.255.255 with proto 17 accepted.
- i_mac_last on payload byte 10 of 40, then reset asserted mid-header of the next frame: last with byte 10 and o_drop pulse; all outputs 0 during reset; next full frame parsed normally.
